hs_arbiter: RTL and testbench

//  Clocked round-robin arbiter sharing one 4-phase (return-to-zero) req/ack output channel among N

---
 rtl/hs_arbiter.sv | 202 ++++++++++++++++++++
 tb/tb_hs_arbiter.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hs_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : hs_arbiter
// Description : Clocked round-robin arbiter that shares one 4-phase
//               (return-to-zero) req/ack output channel among N requester
//               channels. It drives the shared request, returns the granted
//               requester's acknowledge and exports the grant index so the
//               bundled-data mux can be steered. Handshake inputs may be
//               asynchronous to clk and are synchronised internally.
// Ports       : clk    - clock, rising edge
//               rst    - asynchronous reset, active-high
//               r_i    - [N]  requests from requester channels
//               a_i    - [N]  acknowledges to requesters (one-hot or zero)
//               r_o    - request to the shared channel
//               a_o    - acknowledge from the shared channel
//               sel_o  - [SW] index of the granted channel (data mux select)
//               busy   - high whenever the FSM is not idle
// Revision    : 1.0 - initial release
// ============================================================================
module hs_arbiter #(
    parameter int N           = 4,
    parameter int SYNC_STAGES = 2,
    localparam int SW         = (N > 1) ? $clog2(N) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [N-1:0]  r_i,
    output logic [N-1:0]  a_i,
    output logic          r_o,
    input  logic          a_o,
    output logic [SW-1:0] sel_o,
    output logic          busy
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_GRANT = 3'd1,
        ST_REQ   = 3'd2,
        ST_ACK   = 3'd3,
        ST_RTZ   = 3'd4
    } state_t;

    // Pointer starts at the last channel so channel 0 is scanned first.
    localparam logic [SW-1:0] C_PTR_RST = SW'(N - 1);

    // ------------------------------------------------------------------
    // Input synchronisers: a_o and r_i share one chain ({a_o, r_i}).
    // ------------------------------------------------------------------
    logic [N:0] w_raw;
    logic [N:0] w_sync;
    logic [N-1:0] w_rs;
    logic         w_as;

    assign w_raw = {a_o, r_i};

    generate
        if (SYNC_STAGES > 0) begin : g_sync
            logic [N:0] sync_q [SYNC_STAGES];

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    for (int s = 0; s < SYNC_STAGES; s++) begin
                        sync_q[s] <= '0;
                    end
                end else begin
                    sync_q[0] <= w_raw;
                    for (int s = 1; s < SYNC_STAGES; s++) begin
                        sync_q[s] <= sync_q[s-1];
                    end
                end
            end

            assign w_sync = sync_q[SYNC_STAGES-1];
        end else begin : g_nosync
            // Inputs are already synchronous to clk.
            assign w_sync = w_raw;
        end
    endgenerate

    assign w_rs = w_sync[N-1:0];
    assign w_as = w_sync[N];

    // ------------------------------------------------------------------
    // State and registered outputs
    // ------------------------------------------------------------------
    state_t          state_q, state_d;
    logic [SW-1:0]   ptr_q,   ptr_d;
    logic [SW-1:0]   sel_q,   sel_d;
    logic [N-1:0]    a_i_q,   a_i_d;
    logic            r_o_q,   r_o_d;
    logic            busy_q,  busy_d;

    // ------------------------------------------------------------------
    // Round-robin pick: first set request scanning ptr+1, ptr+2, ...
    // wrapping modulo N. The wrap is a single conditional subtract since
    // ptr+k never reaches 2N.
    // ------------------------------------------------------------------
    logic            w_found;
    logic [SW-1:0]   w_pick;

    always_comb begin : p_pick
        logic [SW:0] sum;
        w_found = 1'b0;
        w_pick  = ptr_q;
        sum     = '0;
        for (int k = 1; k <= N; k++) begin
            sum = {1'b0, ptr_q} + (SW+1)'(k);
            if (sum >= (SW+1)'(N)) begin
                sum = sum - (SW+1)'(N);
            end
            if (!w_found && w_rs[sum[SW-1:0]]) begin
                w_found = 1'b1;
                w_pick  = sum[SW-1:0];
            end
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic. Outputs are decoded from the next state and
    // registered, so nothing on the output pins is combinational from
    // the inputs.
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        sel_d   = sel_q;

        case (state_q)
            ST_IDLE: begin
                // Other requests are only looked at here, so a running
                // transaction is never preempted.
                if (w_found) begin
                    state_d = ST_GRANT;
                    sel_d   = w_pick;
                    ptr_d   = w_pick;
                end
            end
            ST_GRANT: begin
                // One cycle of data setup before r_o rises. A withdrawn
                // request abandons the grant; a stale ack holds us here
                // until the shared channel has returned to zero.
                if (!w_rs[sel_q]) begin
                    state_d = ST_IDLE;
                end else if (!w_as) begin
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                // The requester's r_i is deliberately ignored here: once
                // r_o is up, the shared channel must see a full handshake.
                if (w_as) begin
                    state_d = ST_ACK;
                end
            end
            ST_ACK: begin
                if (!w_rs[sel_q]) begin
                    state_d = ST_RTZ;
                end
            end
            ST_RTZ: begin
                if (!w_as) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        r_o_d  = (state_d == ST_REQ) || (state_d == ST_ACK);
        busy_d = (state_d != ST_IDLE);
        a_i_d  = '0;
        if ((state_d == ST_ACK) || (state_d == ST_RTZ)) begin
            a_i_d[sel_d] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            ptr_q   <= C_PTR_RST;
            sel_q   <= '0;
            a_i_q   <= '0;
            r_o_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            sel_q   <= sel_d;
            a_i_q   <= a_i_d;
            r_o_q   <= r_o_d;
            busy_q  <= busy_d;
        end
    end

    assign a_i   = a_i_q;
    assign r_o   = r_o_q;
    assign sel_o = sel_q;
    assign busy  = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_hs_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_hs_arbiter
// Description : Self-checking bench for hs_arbiter (N=4, SYNC_STAGES=2).
//               Hand-written cycle-exact sequences cover single request,
//               withdrawal, stale ack and reset mid-transaction; a table of
//               {requests to arm, expected grant} records covers round-robin
//               order. A per-cycle monitor checks the grant/ack invariants.
// Ports       : none
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hs_arbiter;

    localparam int N  = 4;
    localparam int S  = 2;
    localparam int TO = 300;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] r_i;
    logic [3:0] a_i;
    logic       r_o;
    logic       a_o;
    logic [1:0] sel_o;
    logic       busy;

    always #5 clk = ~clk;

    hs_arbiter #(.N(N), .SYNC_STAGES(S)) dut (
        .clk   (clk),
        .rst   (rst),
        .r_i   (r_i),
        .a_i   (a_i),
        .r_o   (r_o),
        .a_o   (a_o),
        .sel_o (sel_o),
        .busy  (busy)
    );

    // Stimulus sources: manual or modelled requesters, manual or modelled peer.
    logic       model_en = 1'b0;
    logic       peer_en  = 1'b1;
    logic       a_man    = 1'b0;
    logic [3:0] r_man    = 4'b0000;
    logic [3:0] r_mod    = 4'b0000;
    logic [2:0] rd       = 3'b000;

    assign r_i = model_en ? r_mod : r_man;
    assign a_o = peer_en  ? rd[2] : a_man;

    // Downstream peer: a_o follows r_o three cycles after each edge.
    always @(posedge clk or posedge rst) begin
        if (rst) rd <= 3'b000;
        else     rd <= {rd[1:0], r_o};
    end

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Wait (bounded) until a_i is nonzero (nz=1) or zero (nz=0).
    task automatic wait_ai(input logic nz, input string name);
        int n = 0;
        while (((a_i != 4'b0000) != nz) && (n < TO)) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= TO) begin
            errors++;
            $display("FAIL %s: timeout after %0d cycles, a_i=0x%0h required nonzero=%0d", name, n, a_i, nz);
        end
    endtask

    // Four-phase requester model: raise when armed, drop on ack.
    int arm_cnt [4] = '{0, 0, 0, 0};
    int served  [4] = '{0, 0, 0, 0};

    initial begin
        forever begin
            @(negedge clk);
            for (int k = 0; k < 4; k++) begin
                if (r_mod[k] && a_i[k]) begin
                    r_mod[k]  = 1'b0;
                    served[k] = served[k] + 1;
                end else if (!r_mod[k] && !a_i[k] && (arm_cnt[k] != served[k])) begin
                    r_mod[k] = 1'b1;
                end
            end
        end
    end

    // Per-cycle invariants.
    logic [1:0] prev_sel = 2'b00;
    logic       prev_act = 1'b0;
    logic       prev_ok  = 1'b0;

    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_ok = 1'b0;
            end else begin
                chk("onehot0_a_i", 32'($onehot0(a_i)), 32'd1);
                chk("a_i_vs_sel", 32'((a_i == 4'b0000) || (a_i == (4'b0001 << sel_o))), 32'd1);
                if (prev_ok && (prev_act || r_o || (a_i != 4'b0000)))
                    chk("sel_stable", 32'(sel_o), 32'(prev_sel));
                prev_sel = sel_o;
                prev_act = r_o || (a_i != 4'b0000);
                prev_ok  = 1'b1;
            end
        end
    end

    typedef struct {
        logic [3:0] arm;
        int         exp_sel;
    } vec_t;

    vec_t tbl [11];

    initial begin
        logic [3:0] onehot;

        // Round-robin table, starting from the reset pointer (3).
        tbl[0]  = '{4'b0010, 1};
        tbl[1]  = '{4'b0001, 0};
        tbl[2]  = '{4'b1000, 3};
        tbl[3]  = '{4'b1111, 0};   // all four at once
        tbl[4]  = '{4'b0001, 1};   // each entry re-arms the channel just served
        tbl[5]  = '{4'b0010, 2};
        tbl[6]  = '{4'b0100, 3};
        tbl[7]  = '{4'b1000, 0};
        tbl[8]  = '{4'b0001, 1};
        tbl[9]  = '{4'b0010, 2};
        tbl[10] = '{4'b0100, 3};

        // ---------------- reset state ----------------
        rst = 1'b1;
        cyc(3);
        chk("rst_a_i",   32'(a_i),   32'h0);
        chk("rst_r_o",   32'(r_o),   32'h0);
        chk("rst_sel",   32'(sel_o), 32'h0);
        chk("rst_busy",  32'(busy),  32'h0);
        rst = 1'b0;
        cyc(4);
        chk("idle_busy", 32'(busy),  32'h0);

        // ---------------- single request on channel 1 ----------------
        r_man = 4'b0010;
        cyc(3);
        chk("t1_grant_busy", 32'(busy),  32'h1);
        chk("t1_grant_sel",  32'(sel_o), 32'h1);
        chk("t1_grant_r_o",  32'(r_o),   32'h0);
        cyc(1);
        chk("t1_req_r_o",    32'(r_o),   32'h1);
        cyc(5);
        chk("t1_pre_ack",    32'(a_i),   32'h0);
        cyc(1);
        chk("t1_ack_a_i",    32'(a_i),   32'h2);
        r_man = 4'b0000;
        cyc(2);
        chk("t1_ack_r_o",    32'(r_o),   32'h1);
        cyc(1);
        chk("t1_rtz_r_o",    32'(r_o),   32'h0);
        chk("t1_rtz_a_i",    32'(a_i),   32'h2);
        cyc(5);
        chk("t1_rtz_hold",   32'(a_i),   32'h2);
        chk("t1_rtz_busy",   32'(busy),  32'h1);
        cyc(1);
        chk("t1_idle_a_i",   32'(a_i),   32'h0);
        chk("t1_idle_busy",  32'(busy),  32'h0);
        cyc(3);

        // ---------------- withdraw (ptr 1 -> 2) ----------------
        // One-cycle pulse: gone from rs by the time GRANT is evaluated.
        r_man = 4'b0100;
        cyc(1);
        r_man = 4'b0000;
        chk("t3_r_o_0", 32'(r_o), 32'h0);
        cyc(2);
        chk("t3_grant_busy", 32'(busy),  32'h1);
        chk("t3_grant_sel",  32'(sel_o), 32'h2);
        chk("t3_grant_r_o",  32'(r_o),   32'h0);
        cyc(1);
        chk("t3_idle_busy",  32'(busy),  32'h0);
        for (int i = 0; i < 5; i++) begin
            cyc(1);
            chk("t3_no_r_o", 32'(r_o), 32'h0);
        end

        // ---------------- stale ack; also proves ptr=2 ----------------
        peer_en = 1'b0;
        a_man   = 1'b1;
        cyc(4);
        r_man = 4'b0110;           // ptr=2 scans 3,0,1 -> channel 1
        cyc(3);
        chk("t4_grant_sel",  32'(sel_o), 32'h1);
        chk("t4_grant_busy", 32'(busy),  32'h1);
        chk("t4_grant_r_o",  32'(r_o),   32'h0);
        cyc(3);
        chk("t4_stale_r_o",  32'(r_o),   32'h0);
        chk("t4_stale_busy", 32'(busy),  32'h1);
        a_man = 1'b0;
        cyc(2);
        chk("t4_pre_req",    32'(r_o),   32'h0);
        cyc(1);
        chk("t4_req_r_o",    32'(r_o),   32'h1);
        a_man = 1'b1;
        cyc(2);
        chk("t4_pre_ack",    32'(a_i),   32'h0);
        cyc(1);
        chk("t4_ack_a_i",    32'(a_i),   32'h2);
        r_man = 4'b0000;
        cyc(2);
        chk("t4_ack_r_o",    32'(r_o),   32'h1);
        cyc(1);
        chk("t4_rtz_r_o",    32'(r_o),   32'h0);
        chk("t4_rtz_a_i",    32'(a_i),   32'h2);
        a_man = 1'b0;
        cyc(2);
        chk("t4_rtz_hold",   32'(a_i),   32'h2);
        cyc(1);
        chk("t4_idle_a_i",   32'(a_i),   32'h0);
        chk("t4_idle_busy",  32'(busy),  32'h0);
        peer_en = 1'b1;
        cyc(3);

        // ---------------- reset mid-ACK ----------------
        r_man = 4'b0100;
        wait_ai(1'b1, "t5_wait_ack");
        chk("t5_ack_a_i", 32'(a_i),   32'h4);
        chk("t5_ack_r_o", 32'(r_o),   32'h1);
        chk("t5_ack_sel", 32'(sel_o), 32'h2);
        #2 rst = 1'b1;
        #1;
        chk("t5_async_a_i",  32'(a_i),   32'h0);
        chk("t5_async_r_o",  32'(r_o),   32'h0);
        chk("t5_async_busy", 32'(busy),  32'h0);
        chk("t5_async_sel",  32'(sel_o), 32'h0);
        r_man = 4'b0101;
        cyc(2);
        rst = 1'b0;
        wait_ai(1'b1, "t5_wait_first");
        chk("t5_first_a_i", 32'(a_i),   32'h1);
        chk("t5_first_sel", 32'(sel_o), 32'h0);
        r_man = 4'b0100;
        wait_ai(1'b0, "t5_wait_rtz0");
        wait_ai(1'b1, "t5_wait_second");
        chk("t5_second_a_i", 32'(a_i), 32'h4);
        r_man = 4'b0000;
        wait_ai(1'b0, "t5_wait_rtz2");
        chk("t5_end_busy", 32'(busy), 32'h0);

        // ---------------- round-robin table ----------------
        rst = 1'b1;
        cyc(2);
        rst = 1'b0;
        model_en = 1'b1;
        cyc(2);
        for (int i = 0; i < 11; i++) begin
            wait_ai(1'b0, $sformatf("rr%0d_wait_idle", i));
            for (int k = 0; k < 4; k++)
                if (tbl[i].arm[k]) arm_cnt[k] = arm_cnt[k] + 1;
            wait_ai(1'b1, $sformatf("rr%0d_wait_ack", i));
            onehot = 4'b0001 << tbl[i].exp_sel;
            chk($sformatf("rr%0d_sel", i), 32'(sel_o), 32'(tbl[i].exp_sel));
            chk($sformatf("rr%0d_a_i", i), 32'(a_i),   32'(onehot));
            chk($sformatf("rr%0d_r_o", i), 32'(r_o),   32'h1);
        end

        // Drain the requests still pending from the last entries.
        begin
            int n = 0;
            while (((arm_cnt != served) || busy || (r_i != 4'b0000)) && (n < 4 * TO)) begin
                @(negedge clk);
                n++;
            end
            checks++;
            if (n >= 4 * TO) begin
                errors++;
                $display("FAIL drain: timeout, busy=%0d r_i=0x%0h required idle", busy, r_i);
            end
        end
        cyc(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
